// File: rtl/conv_pkg.sv
// Shared definitions for the convolution input buffers.
// Holds the default data width and vector lengths, the matching address
// widths, and the load/loaded state type used by conv_input_mems.
package conv_pkg;

  localparam int T_DEF = 10;   // sample width in bits
  localparam int N_DEF = 112;  // x samples per convolution
  localparam int M_DEF = 49;   // f coefficients per convolution

  localparam int XA_W = $clog2(N_DEF);
  localparam int FA_W = $clog2(M_DEF);

  typedef enum logic {
    LOAD,
    LOADED
  } in_state_t;

endpackage

// File: rtl/conv_memory.sv
// Simple dual-port buffer: one write port and one registered read port.
// Ports:
//   clk      - clock
//   rst      - asynchronous active-high reset (clears the read register only)
//   data_in  - write data
//   addr_w   - write address
//   wr_en    - write enable
//   addr_r   - read address
//   data_out - read data, valid one cycle after addr_r
// A read of the address being written in the same cycle returns the old word.
module conv_memory #(
  parameter int WIDTH = 10,
  parameter int SIZE  = 112,
  parameter int AW    = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    addr_w,
  input  logic             wr_en,
  input  logic [AW-1:0]    addr_r,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] mem [SIZE];
  logic [WIDTH-1:0] data_out_q;

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_w] <= data_in;
    end
  end

  // Out-of-range read addresses return zero instead of indexing past the array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out_q <= '0;
    end else if (int'(addr_r) < SIZE) begin
      data_out_q <= mem[addr_r];
    end else begin
      data_out_q <= '0;
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/conv_input_mems.sv
// Input buffering for the convolution engine.
// Accepts N x samples and M f coefficients over two independent valid/ready
// streams, stores them, flags inputs_loaded once both are complete, and serves
// registered random-access reads. A compute_finished pulse re-arms loading.
// Ports:
//   clk, reset                - clock, asynchronous active-high reset
//   x_data/x_valid/x_ready    - x sample stream
//   f_data/f_valid/f_ready    - f coefficient stream
//   inputs_loaded             - both buffers full and stable
//   compute_finished          - datapath releases the buffers (1-cycle pulse)
//   x_addr/x_out, f_addr/f_out - read ports, 1-cycle latency
module conv_input_mems
  import conv_pkg::*;
#(
  parameter int T = T_DEF,
  parameter int N = N_DEF,
  parameter int M = M_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [T-1:0]         x_data,
  input  logic                 x_valid,
  output logic                 x_ready,
  input  logic [T-1:0]         f_data,
  input  logic                 f_valid,
  output logic                 f_ready,
  output logic                 inputs_loaded,
  input  logic                 compute_finished,
  input  logic [$clog2(N)-1:0] x_addr,
  output logic [T-1:0]         x_out,
  input  logic [$clog2(M)-1:0] f_addr,
  output logic [T-1:0]         f_out
);

  localparam int XA = $clog2(N);
  localparam int FA = $clog2(M);

  in_state_t     state_q, state_d;
  logic [XA-1:0] x_wcnt_q, x_wcnt_d;
  logic [FA-1:0] f_wcnt_q, f_wcnt_d;
  logic          x_done_q, x_done_d;
  logic          f_done_q, f_done_d;
  logic          loaded_q, loaded_d;

  logic x_wr;
  logic f_wr;

  assign x_ready = (state_q == LOAD) && !x_done_q;
  assign f_ready = (state_q == LOAD) && !f_done_q;
  assign x_wr    = x_valid && x_ready;
  assign f_wr    = f_valid && f_ready;

  always_comb begin
    state_d  = state_q;
    x_wcnt_d = x_wcnt_q;
    f_wcnt_d = f_wcnt_q;
    x_done_d = x_done_q;
    f_done_d = f_done_q;

    // Counter wraps to zero on the last word so it is ready for the next load.
    if (x_wr) begin
      if (x_wcnt_q == XA'(N - 1)) begin
        x_done_d = 1'b1;
        x_wcnt_d = '0;
      end else begin
        x_wcnt_d = x_wcnt_q + 1'b1;
      end
    end

    if (f_wr) begin
      if (f_wcnt_q == FA'(M - 1)) begin
        f_done_d = 1'b1;
        f_wcnt_d = '0;
      end else begin
        f_wcnt_d = f_wcnt_q + 1'b1;
      end
    end

    case (state_q)
      LOAD: begin
        if (x_done_q && f_done_q) begin
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (compute_finished) begin
          state_d  = LOAD;
          x_done_d = 1'b0;
          f_done_d = 1'b0;
        end
      end
      default: state_d = LOAD;
    endcase

    loaded_d = (state_d == LOADED);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= LOAD;
      x_wcnt_q <= '0;
      f_wcnt_q <= '0;
      x_done_q <= 1'b0;
      f_done_q <= 1'b0;
      loaded_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_wcnt_q <= x_wcnt_d;
      f_wcnt_q <= f_wcnt_d;
      x_done_q <= x_done_d;
      f_done_q <= f_done_d;
      loaded_q <= loaded_d;
    end
  end

  assign inputs_loaded = loaded_q;

  conv_memory #(.WIDTH(T), .SIZE(N), .AW(XA)) u_mem_x (
    .clk      (clk),
    .rst      (reset),
    .data_in  (x_data),
    .addr_w   (x_wcnt_q),
    .wr_en    (x_wr),
    .addr_r   (x_addr),
    .data_out (x_out)
  );

  conv_memory #(.WIDTH(T), .SIZE(M), .AW(FA)) u_mem_f (
    .clk      (clk),
    .rst      (reset),
    .data_in  (f_data),
    .addr_w   (f_wcnt_q),
    .wr_en    (f_wr),
    .addr_r   (f_addr),
    .data_out (f_out)
  );

endmodule

// File: tb/tb_conv_input_mems.sv
module tb_conv_input_mems;

  localparam int T = 10;
  localparam int N = 112;
  localparam int M = 49;

  logic         clk = 1'b0;
  logic         reset;
  logic [T-1:0] x_data, f_data;
  logic         x_valid, f_valid;
  logic         x_ready, f_ready;
  logic         inputs_loaded;
  logic         compute_finished;
  logic [6:0]   x_addr;
  logic [5:0]   f_addr;
  logic [T-1:0] x_out, f_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  conv_input_mems #(.T(T), .N(N), .M(M)) dut (
    .clk              (clk),
    .reset            (reset),
    .x_data           (x_data),
    .x_valid          (x_valid),
    .x_ready          (x_ready),
    .f_data           (f_data),
    .f_valid          (f_valid),
    .f_ready          (f_ready),
    .inputs_loaded    (inputs_loaded),
    .compute_finished (compute_finished),
    .x_addr           (x_addr),
    .x_out            (x_out),
    .f_addr           (f_addr),
    .f_out            (f_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [T-1:0] xval(input int z);
    return T'(z - 128);
  endfunction

  function automatic logic [T-1:0] fval(input int z);
    return T'(z - 64);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams one full x/f set. Stream k carries sequence index off+k.
  // Each stream starts after its delay; rnd inserts random valid gaps with X data.
  // cfmid: cycle on which a stray compute_finished pulse is driven (-1 = none).
  task automatic load(input int xoff, input int foff, input int xdelay, input int fdelay,
                      input bit rnd, input int cfmid);
    int xi = 0;
    int fi = 0;
    int cyc = 0;
    bit xv, fv;
    while ((xi < N || fi < M) && cyc < 3000) begin
      check($sformatf("x_ready c%0d", cyc), 32'(x_ready), (xi < N) ? 1 : 0);
      check($sformatf("f_ready c%0d", cyc), 32'(f_ready), (fi < M) ? 1 : 0);
      check($sformatf("loaded_early c%0d", cyc), 32'(inputs_loaded), 0);
      xv = (cyc >= xdelay) && (!rnd || $urandom_range(0, 3) != 0);
      fv = (cyc >= fdelay) && (!rnd || $urandom_range(0, 3) != 0);
      x_valid = xv;
      f_valid = fv;
      x_data  = xv ? ((xi < N) ? xval(xoff + xi) : 10'h1ff) : 'x;
      f_data  = fv ? ((fi < M) ? fval(foff + fi) : 10'h1ff) : 'x;
      compute_finished = (cyc == cfmid);
      tick();
      if (xv && xi < N) xi++;
      if (fv && fi < M) fi++;
      cyc++;
    end
    // Keep offering garbage: nothing may be written once both buffers are full.
    x_valid = 1'b1;
    f_valid = 1'b1;
    x_data  = 10'h1ff;
    f_data  = 10'h1ff;
    compute_finished = 1'b0;
    check("load_complete", (xi == N && fi == M) ? 1 : 0, 1);
    check("loaded_lag", 32'(inputs_loaded), 0);
    check("x_ready_full", 32'(x_ready), 0);
    check("f_ready_full", 32'(f_ready), 0);
    tick();
    check("inputs_loaded", 32'(inputs_loaded), 1);
    check("x_ready_loaded", 32'(x_ready), 0);
    check("f_ready_loaded", 32'(f_ready), 0);
    tick();
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = 'x;
    f_data  = 'x;
  endtask

  task automatic readback(input int xoff, input int foff);
    for (int a = 0; a < N; a++) begin
      x_addr = 7'(a);
      f_addr = 6'(a % M);
      tick();
      check($sformatf("x_out[%0d]", a), 32'(x_out), 32'(xval(xoff + a)));
      if (a < M) check($sformatf("f_out[%0d]", a), 32'(f_out), 32'(fval(foff + a)));
    end
    check("still_loaded", 32'(inputs_loaded), 1);
  endtask

  task automatic release_bufs();
    compute_finished = 1'b1;
    tick();
    compute_finished = 1'b0;
    check("rel_x_ready", 32'(x_ready), 1);
    check("rel_f_ready", 32'(f_ready), 1);
    check("rel_loaded", 32'(inputs_loaded), 0);
  endtask

  initial begin
    reset = 1'b1;
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data = '0;
    f_data = '0;
    compute_finished = 1'b0;
    x_addr = '0;
    f_addr = '0;
    #1;
    check("rst_loaded", 32'(inputs_loaded), 0);
    check("rst_x_out", 32'(x_out), 0);
    check("rst_f_out", 32'(f_out), 0);
    tick();
    tick();
    reset = 1'b0;
    check("post_rst_x_ready", 32'(x_ready), 1);
    check("post_rst_f_ready", 32'(f_ready), 1);
    check("post_rst_loaded", 32'(inputs_loaded), 0);

    // Back-to-back first set
    load(0, 0, 0, 0, 1'b0, -1);
    readback(0, 0);
    x_addr = 7'd0;  f_addr = 6'd48;
    tick();
    check("x0_first", 32'(x_out), 32'(10'h380));   // -128
    check("f48_first", 32'(f_out), 32'(10'h3f0));  // -16
    x_addr = 7'd111;
    tick();
    check("x111_first", 32'(x_out), 32'(10'h3ef)); // -17

    // Second set with random gaps and a stray compute_finished during loading
    release_bufs();
    load(112, 49, 0, 0, 1'b1, 20);
    readback(112, 49);
    x_addr = 7'd0;  f_addr = 6'd0;
    tick();
    check("x0_second", 32'(x_out), 32'(10'h3f0));  // -16
    check("f0_second", 32'(f_out), 32'(10'h3f1));  // -15

    // f finishes first, x completes 50 cycles later
    release_bufs();
    load(0, 0, 0, 13, 1'b0, -1);
    readback(0, 0);

    // Last x and last f transfer on the same edge
    release_bufs();
    load(0, 0, 0, 63, 1'b0, -1);
    readback(0, 0);

    // Reset in the middle of a load, then reload the first set
    release_bufs();
    for (int i = 0; i < 30; i++) begin
      x_valid = 1'b1;
      x_data  = xval(500 + i);
      f_valid = (i < 10);
      f_data  = (i < 10) ? fval(500 + i) : 'x;
      tick();
    end
    x_valid = 1'b0;
    f_valid = 1'b0;
    x_data  = 'x;
    f_data  = 'x;
    #2;
    reset = 1'b1;
    #1;
    check("midrst_loaded", 32'(inputs_loaded), 0);
    check("midrst_x_out", 32'(x_out), 0);
    check("midrst_f_out", 32'(f_out), 0);
    check("midrst_x_ready", 32'(x_ready), 1);
    tick();
    reset = 1'b0;
    load(0, 0, 0, 0, 1'b1, -1);
    readback(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_input_mems.md
Name: conv_input_mems

Overview:
- Receiving end of the x and f valid/ready input streams that feed the convolution engine (for example conv_112_49).
- Accepts N input samples and M filter coefficients as two independent streams and stores them in two synchronous-read memories.
- Asserts inputs_loaded once both memories are full, then serves random-access reads to the compute datapath.
- Re-arms for the next vector/filter pair when the datapath pulses compute_finished.

Parameters:
- T, 10, data width in bits of x and f samples (signed).
- N, 112, number of x samples per convolution.
- M, 49, number of f coefficients per convolution.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- x_data  input  T  signed x sample; may be X when x_valid=0.
- x_valid  input  1  producer has a valid x sample.
- x_ready  output  1  block can accept an x sample this cycle.
- f_data  input  T  signed f coefficient; may be X when f_valid=0.
- f_valid  input  1  producer has a valid f coefficient.
- f_ready  output  1  block can accept an f coefficient this cycle.
- inputs_loaded  output  1  both memories are full; contents are stable.
- compute_finished  input  1  one-cycle pulse from the datapath releasing the buffers.
- x_addr  input  $clog2(N)  x read address.
- x_out  output  T  x memory read data; 1-cycle latency.
- f_addr  input  $clog2(M)  f read address.
- f_out  output  T  f memory read data; 1-cycle latency.

Behaviour:
- Reset values:
  - state=LOAD, x_wcnt=0, f_wcnt=0, x_done=0, f_done=0.
  - inputs_loaded=0, x_out=0, f_out=0.
  - x_ready=1 and f_ready=1 once reset deasserts. Both are combinational from state and the done flags.
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. No other cycle writes memory; X data on invalid cycles must never be stored.
- x_ready = (state==LOAD) && !x_done. f_ready = (state==LOAD) && !f_done.
- The x and f streams are fully independent: either may finish first, and either may stall arbitrarily.
- On an x transfer: mem_x[x_wcnt] <= x_data. If x_wcnt==N-1, set x_done and clear x_wcnt; otherwise increment x_wcnt. The f path behaves identically, bounded by M.
- State LOAD -> LOADED on the edge after both x_done and f_done are set. This includes the case where the last x and last f transfer in the same cycle.
- inputs_loaded is registered. It reads 1 exactly in state LOADED, starting the cycle after the final transfer of the later-finishing stream.
- In LOADED: x_ready=f_ready=0, so no writes occur. Reads are permitted in any state.
- LOADED -> LOAD on compute_finished=1. In that same edge, clear x_done, f_done and inputs_loaded; ready signals return high the next cycle.
- compute_finished while in LOAD is ignored; counters are unaffected.
- Reads: x_out <= mem_x[x_addr] every cycle (registered; the value is valid one cycle after the address). f_out behaves the same. A read of an address being written in the same cycle returns the old data.
- An out-of-range address (x_addr>=N or f_addr>=M) gives undefined data but must not corrupt state.
- Reset asserted mid-load returns immediately to the reset values. Memory contents need not be cleared; partial data is discarded logically because the counters restart at 0.
- No arithmetic beyond counters. Counter widths are $clog2(N) and $clog2(M). Counters never exceed N-1 and M-1.

Decomposition:
- Package conv_pkg holds:
  - defaults T_DEF=10, N_DEF=112, M_DEF=49;
  - widths XA_W=$clog2(N_DEF) and FA_W=$clog2(M_DEF);
  - typedef enum logic {LOAD, LOADED} in_state_t.
- One sub-module, conv_memory #(WIDTH, SIZE): single write port (data_in, addr_w, wr_en) and one synchronous read port (addr_r, data_out, registered). It is instantiated twice, once for x and once for f.
- The top module holds only the FSM, the write counters and the done flags.

Test Plan:
- Back-to-back load, valid=1 every cycle, x=z-128 for z=0..111 and f=z-64 for z=0..48 -> x_ready drops after 112 transfers and f_ready after 49. inputs_loaded=1 on the cycle after the 112th x transfer. Read x_addr=0 -> x_out=-128 next cycle; x_addr=111 -> -17; f_addr=48 -> -16.
- Random valid gaps with data=X on invalid cycles -> no X ever appears on x_out/f_out for addresses 0..N-1 and 0..M-1, and all stored values match the sequence above.
- f stream finishes first, x completes 50 cycles later -> f_ready=0 and x_ready=1 during the gap; inputs_loaded rises exactly one cycle after the last x transfer.
- Last x and last f transfer in the same cycle -> inputs_loaded=1 the next cycle, with no extra write.
- In LOADED, pulse compute_finished, then load a second set with x=z-128 for z=112..223 and f=z-64 for z=49..97 -> ready signals high the cycle after the pulse. A compute_finished pulse asserted during this second load has no effect. After the second load, x_out at addr 0 is -16 and f_out at addr 0 is -15.
- Assert reset after 30 x and 10 f transfers, then reload the full first set -> inputs_loaded stays 0 until all 112 and 49 new transfers complete; stored data equals the first-set values.
